// File: rtl/ll_pkg.sv
// Shared definitions for the LL/SC reservation table.
// Contents:
//   ctx_w()     - context-index width, never narrower than one bit
//   DefGran     - default log2 reservation granule size in bytes
//   DefTimeout  - default reservation lifetime in cycles
//   RstActive   - level of rst that resets state (active-low)
package ll_pkg;

  localparam int unsigned DefGran    = 2;
  localparam int unsigned DefTimeout = 1024;
  localparam logic        RstActive  = 1'b0;

  function automatic int unsigned ctx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ll_resv_entry.sv
// One context's reservation: valid bit, granule tag and, with LL_TIMEOUT_EN
// defined, a lifetime counter.
// Ports:
//   clk, rst    - clock, synchronous active-low reset
//   flush_i     - exception/eret flush for this context
//   ll_set_i    - LL commit targets this context; ll_tag_i is its granule
//   sc_own_i    - SC issued by this context (always ends the reservation)
//   sc_win_i    - some context's SC succeeded on granule sc_tag_i
//   snoop_i     - committed store to granule st_tag_i
//   valid_o     - reservation valid
//   tag_o       - reserved granule
module ll_resv_entry import ll_pkg::*; #(
  parameter int unsigned TAG_W   = 30,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             ll_set_i,
  input  logic [TAG_W-1:0] ll_tag_i,
  input  logic             sc_own_i,
  input  logic             sc_win_i,
  input  logic [TAG_W-1:0] sc_tag_i,
  input  logic             snoop_i,
  input  logic [TAG_W-1:0] st_tag_i,
  output logic             valid_o,
  output logic [TAG_W-1:0] tag_o
);

  logic             valid_q, valid_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             snoop_hit, win_hit, expired, clr;

  // A store to the granule being loaded this same cycle also kills the new
  // reservation, so snoop is checked against both old and incoming tags.
  assign snoop_hit = snoop_i && ((valid_q && tag_q == st_tag_i) ||
                                 (ll_set_i && ll_tag_i == st_tag_i));
  assign win_hit   = sc_win_i && valid_q && tag_q == sc_tag_i;

`ifdef LL_TIMEOUT_EN
  localparam int unsigned TmrW = ctx_w(TIMEOUT);
  logic [TmrW-1:0] tmr_q, tmr_d;

  // Last cycle of life is count TIMEOUT-1; a fresh LL restarts the lifetime.
  assign expired = valid_q && !ll_set_i && tmr_q == TmrW'(TIMEOUT - 1);
`else
  assign expired = 1'b0;
`endif

  assign clr = sc_own_i || win_hit || snoop_hit || expired;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    if (flush_i || clr) begin
      valid_d = 1'b0;
    end else if (ll_set_i) begin
      valid_d = 1'b1;
      tag_d   = ll_tag_i;
    end
  end

`ifdef LL_TIMEOUT_EN
  always_comb begin
    tmr_d = '0;
    if (!flush_i && !clr && !ll_set_i && valid_q) begin
      tmr_d = tmr_q + TmrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstActive) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst == RstActive) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
    end
  end

  assign valid_o = valid_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/ll_resv_table.sv
// Load-linked / store-conditional reservation table, one entry per context.
// Optional feature macro: LL_TIMEOUT_EN (reservations expire after TIMEOUT
// cycles); without it reservations last until SC, snoop or flush.
// Ports:
//   clk, rst                   - clock, synchronous active-low reset
//   flush[NUM_CTX]             - per-context exception/eret flush
//   ll_we, ll_ctx, ll_addr     - LL commit
//   sc_req, sc_ctx, sc_addr    - SC check request
//   st_snoop, st_addr          - committed store from any agent
//   sc_ok, sc_done             - registered SC result, qualified by sc_done
//   llbit_o[NUM_CTX]           - per-context reservation valid
module ll_resv_table import ll_pkg::*; #(
  parameter int unsigned NUM_CTX = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned GRAN    = DefGran,
  parameter int unsigned TIMEOUT = DefTimeout,
  localparam int unsigned CTX_W  = ctx_w(NUM_CTX)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CTX-1:0] flush,
  input  logic              ll_we,
  input  logic [CTX_W-1:0]  ll_ctx,
  input  logic [ADDR_W-1:0] ll_addr,
  input  logic              sc_req,
  input  logic [CTX_W-1:0]  sc_ctx,
  input  logic [ADDR_W-1:0] sc_addr,
  input  logic              st_snoop,
  input  logic [ADDR_W-1:0] st_addr,
  output logic              sc_ok,
  output logic              sc_done,
  output logic [NUM_CTX-1:0] llbit_o
);

  localparam int unsigned TagW = ADDR_W - GRAN;

  logic [TagW-1:0]    ll_tag, sc_tag, st_tag;
  logic [NUM_CTX-1:0] ctx_valid;
  logic [TagW-1:0]    ctx_tag [NUM_CTX];
  logic               sc_hit, sc_win;
  logic               sc_ok_q, sc_done_q;
  logic               unused_low_bits;

  assign ll_tag = ll_addr[ADDR_W-1:GRAN];
  assign sc_tag = sc_addr[ADDR_W-1:GRAN];
  assign st_tag = st_addr[ADDR_W-1:GRAN];
  assign unused_low_bits = ^{ll_addr[GRAN-1:0], sc_addr[GRAN-1:0], st_addr[GRAN-1:0]};

  // Out-of-range sc_ctx matches no entry, so the SC simply fails.
  always_comb begin
    sc_hit = 1'b0;
    for (int c = 0; c < NUM_CTX; c++) begin
      if (sc_ctx == CTX_W'(c)) begin
        sc_hit = ctx_valid[c] && ctx_tag[c] == sc_tag && !flush[c];
      end
    end
  end

  assign sc_win = sc_req && sc_hit && !(st_snoop && st_tag == sc_tag);

  for (genvar c = 0; c < NUM_CTX; c++) begin : g_ctx
    ll_resv_entry #(
      .TAG_W   (TagW),
      .TIMEOUT (TIMEOUT)
    ) u_entry (
      .clk      (clk),
      .rst      (rst),
      .flush_i  (flush[c]),
      .ll_set_i (ll_we && ll_ctx == CTX_W'(c)),
      .ll_tag_i (ll_tag),
      .sc_own_i (sc_req && sc_ctx == CTX_W'(c)),
      .sc_win_i (sc_win),
      .sc_tag_i (sc_tag),
      .snoop_i  (st_snoop),
      .st_tag_i (st_tag),
      .valid_o  (ctx_valid[c]),
      .tag_o    (ctx_tag[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst == RstActive) begin
      sc_ok_q   <= 1'b0;
      sc_done_q <= 1'b0;
    end else begin
      sc_ok_q   <= sc_win;
      sc_done_q <= sc_req;
    end
  end

  assign sc_ok   = sc_ok_q;
  assign sc_done = sc_done_q;
  assign llbit_o = ctx_valid;

endmodule

// File: doc/ll_resv_table.md
LL_RESV_TABLE -- requirements
Module: ll_resv_table

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter NUM_CTX, default 2, number of hardware contexts (1..8).
REQ-003 Parameter ADDR_W, default 32, physical address width.
REQ-004 Parameter GRAN, default 2, log2 of reservation granule bytes; tag compare uses ADDR_W-1:GRAN.
REQ-005 Parameter TIMEOUT, default 1024, reservation lifetime in cycles (used only under LL_TIMEOUT_EN).
REQ-006 Derived CTX_W = max(1, clog2(NUM_CTX)).
REQ-007 clk  in  1  clock, all state on rising edge.
REQ-008 rst  in  1  synchronous reset, active-low.
REQ-009 flush  in  NUM_CTX  per-context exception/eret flush.
REQ-010 ll_we  in  1 ; ll_ctx  in  CTX_W ; ll_addr  in  ADDR_W  -- LL commit.
REQ-011 sc_req  in  1 ; sc_ctx  in  CTX_W ; sc_addr  in  ADDR_W  -- SC check.
REQ-012 st_snoop  in  1 ; st_addr  in  ADDR_W  -- any committed store, any agent.
REQ-013 sc_ok  out  1  registered SC result; sc_done  out  1  one-cycle pulse qualifying sc_ok.
REQ-014 llbit_o  out  NUM_CTX  per-context reservation valid (CP0 LLbit view).

Function
REQ-015 Per context c: valid[c] and tag[c]; match(c,A) = valid[c] && tag[c] == A[ADDR_W-1:GRAN].
REQ-016 ll_we: next cycle valid[ll_ctx]=1, tag loaded, timer cleared; llbit_o updates 1 cycle after ll_we.
REQ-017 sc_req: sc_ok/sc_done appear the following cycle (latency 1); sc_ok = match(sc_ctx,sc_addr) on pre-edge state && !flush[sc_ctx] && !(st_snoop && st_addr granule == sc_addr granule).
REQ-018 sc_req always clears valid[sc_ctx], success or fail.
REQ-019 Successful SC also clears every other context matching sc_addr granule.
REQ-020 st_snoop clears every context c with match(c,st_addr).
REQ-021 Per-context next-state priority: reset > flush > clear (SC, snoop, SC-success, timeout) > LL set.
REQ-022 LL and SC same context same cycle: SC uses old state; reservation ends invalid.
REQ-023 LL and matching snoop same cycle, same granule: reservation ends invalid.
REQ-024 ll_ctx or sc_ctx >= NUM_CTX: request ignored, sc_done still pulses with sc_ok=0.
REQ-025 sc_done=0 and sc_ok=0 in every cycle not following an sc_req.

Reset
REQ-026 rst low at edge: all valid=0, tags=0, timers=0, sc_ok=0, sc_done=0, llbit_o=0.
REQ-027 sc_req coincident with reset produces no sc_done afterward.

Configuration
REQ-028 Macro LL_TIMEOUT_EN defined: per-context counter increments while valid; at count TIMEOUT-1 without new LL, valid clears, so reservation lasts exactly TIMEOUT cycles.
REQ-029 LL_TIMEOUT_EN undefined: no counters synthesised, TIMEOUT ignored, reservation persists until cleared by REQ-018..021.

Structure
REQ-030 Shared package ll_pkg: CTX_W function, default GRAN/TIMEOUT constants, active-low reset level constant.
REQ-031 One sub-module ll_resv_entry (valid, tag, optional timer, priority logic), instantiated NUM_CTX times by generate.

Verification
REQ-032 LL ctx0 0x1000, SC ctx0 0x1002 after 3 cycles -> sc_ok=1, llbit_o[0]=0 after.
REQ-033 LL ctx0 0x1000, snoop 0x1004 then SC ctx0 0x1000 -> snoop ignored (different word), sc_ok=1; snoop 0x1000 instead -> sc_ok=0.
REQ-034 LL ctx0 and ctx1 at 0x2000, SC ctx1 0x2000 succeeds -> llbit_o=2'b00, later SC ctx0 -> sc_ok=0.
REQ-035 LL ctx1 0x3000, flush[1] same cycle as SC ctx1 0x3000 -> sc_ok=0; LL with flush same cycle -> llbit_o[1]=0.
REQ-036 LL_TIMEOUT_EN, TIMEOUT=4: LL ctx0, SC at cycle 4 after LL -> sc_ok=1; at cycle 5 -> sc_ok=0.
REQ-037 rst low mid-reservation with sc_req -> all outputs 0, no sc_done pulse.
